ex_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide execution unit for the EX stage; replaces the

---
 rtl/ex_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional feature: define MULDIV_EARLY_OUT_EN for single-cycle trivial mul/div results.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic              s1_q, s2_q, dz_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   b_q;

  logic              signed_op, in_s1, in_s2, accept, early;
  logic [XLEN-1:0]   mag1, mag2;

  assign signed_op = in_op[2] ? ~in_op[0] : ~in_op[1];
  assign in_s1     = signed_op & in_src1[XLEN-1];
  assign in_s2     = signed_op & in_src2[XLEN-1];
  assign mag1      = in_s1 ? -in_src1 : in_src1;
  assign mag2      = in_s2 ? -in_src2 : in_src2;
  assign accept    = in_valid & ~flush & (state == IDLE);

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early = 1'b0;
    if (in_op[2])
      early = (in_src2 != '0) && (mag1 < mag2);
    else
      early = (in_src1 == '0) || (in_src2 == '0);
  end
`else
  assign early = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // p holds {hi, lo}: product for mul, {remainder, dividend/quotient} for div
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] p_step;

  always_comb begin
    mul_sum   = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b_q} : '0);
    div_shift = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift - {1'b0, b_q};
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    p_step    = op_q[2] ? {div_rem, p[XLEN-2:0], div_ge}
                        : {mul_sum[XLEN:0], p[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  always_comb begin
    prod    = (s1_q ^ s2_q) ? -p : p;
    quo_fix = dz_q ? '1 : ((s1_q ^ s2_q) ? -p[XLEN-1:0] : p[XLEN-1:0]);
    rem_fix = s1_q ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (op_q[2])
      final_result = op_q[1] ? rem_fix : quo_fix;
    else
      final_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Early-out skips the iterations and lands directly on the final sign-fix cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
      op_q       <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      dz_q       <= 1'b0;
      p          <= '0;
      b_q        <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q    <= in_op;
          out_tag <= in_tag;
          s1_q    <= in_s1;
          s2_q    <= in_s2;
          dz_q    <= in_op[2] & (in_src2 == '0);
          b_q     <= mag2;
          if (early) begin
            p   <= in_op[2] ? {mag1, {XLEN{1'b0}}} : '0;
            cnt <= LAST;
          end else begin
            p   <= {{XLEN{1'b0}}, mag1};
            cnt <= '0;
          end
        end
        CALC: if (cnt == LAST) begin
          out_result <= final_result;
        end else begin
          p   <= p_step;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors plus random ops against a scoreboard.
// Expected latencies follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_ex_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_src1, in_src2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          t_acc;
  } exp_t;
  exp_t sb[$];

  ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers, independent of the iterative datapath
  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint      sa, sbv;
    logic [63:0] sp, up;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sp  = 64'(sa * sbv);
    up  = {32'b0, a} * {32'b0, b};
    r   = '0;
    case (op)
      3'd0: r = sp[31:0];
      3'd1: r = sp[63:32];
      3'd2: r = up[63:32];
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sbv);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sbv);
      3'd7: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    longint ma, mb;
    bit     early;
    ma = (op == 3'd4 || op == 3'd6) ? longint'($signed(a)) : longint'({32'b0, a});
    mb = (op == 3'd4 || op == 3'd6) ? longint'($signed(b)) : longint'({32'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (op[2]) early = (b != 0) && (ma < mb);
    else       early = (a == 0) || (b == 0);
    return (EARLY_EN && early) ? 1 : XLEN + 1;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    checkValue("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0; in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'($urandom);
    e.res = exp; e.tag = tag; e.lat = expLatency(op, a, b); e.t_acc = cyc;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int hold);
    exp_t e;
    int   waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    e = sb.pop_front();
    checkValue("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    checkValue("latency", cyc - e.t_acc, e.lat);
    checkValue("out_result", out_result, e.res);
    checkValue("out_tag", {27'b0, out_tag}, {27'b0, e.tag});
    checkValue("in_ready_done", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkValue("hold_valid", {31'b0, out_valid}, 32'd1);
      checkValue("hold_result", out_result, e.res);
      checkValue("hold_tag", {27'b0, out_tag}, {27'b0, e.tag});
      checkValue("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkValue("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    checkValue("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
  endtask

  logic [2:0] op_list [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    checkValue("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("rst_busy", {31'b0, busy}, 32'd0);
    checkValue("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("rst_out_result", out_result, 32'd0);
    checkValue("rst_out_tag", {27'b0, out_tag}, 32'd0);
    reset = 1'b0;

    applyStimulus(3'd0, 32'hFFFFFFFF, 32'd5, 5'd1, 32'hFFFFFFFB); checkOutput(0);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'd5, 5'd2, 32'hFFFFFFFF); checkOutput(0);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'd5, 5'd3, 32'h00000004); checkOutput(0);

    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD); checkOutput(0);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF); checkOutput(0);
    applyStimulus(3'd5, 32'hFFFFFFF9, 32'd2, 5'd6, 32'h7FFFFFFC); checkOutput(0);
    applyStimulus(3'd7, 32'hFFFFFFF9, 32'd2, 5'd7, 32'h00000001); checkOutput(0);

    applyStimulus(3'd4, 32'd10, 32'd0, 5'd8, 32'hFFFFFFFF); checkOutput(0);
    applyStimulus(3'd6, 32'd10, 32'd0, 5'd9, 32'h0000000A); checkOutput(0);
    applyStimulus(3'd6, 32'hFFFFFFF6, 32'd0, 5'd10, 32'hFFFFFFF6); checkOutput(0);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000); checkOutput(0);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000); checkOutput(0);

    applyStimulus(3'd0, 32'd6, 32'd7, 5'h1F, 32'd42); checkOutput(5);

    // Flush during CALC: result must never appear
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 32'd100; in_src2 = 32'd200; in_tag = 5'd13;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkValue("calc_busy", {31'b0, busy}, 32'd1);
    checkValue("calc_in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkValue("flush_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("flush_busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkValue("flush_no_out_valid", {31'b0, seen}, 32'd0);

    // Flush together with a request in IDLE: not accepted
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 32'd5; in_src2 = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checkValue("flush_idle_busy", {31'b0, busy}, 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd14, 32'h0000000C); checkOutput(0);

    // Reset mid-CALC clears everything
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd2; in_src1 = 32'hDEADBEEF; in_src2 = 32'h12345678; in_tag = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkValue("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("midrst_out_result", out_result, 32'd0);
    checkValue("midrst_out_tag", {27'b0, out_tag}, 32'd0);
    checkValue("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("midrst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    applyStimulus(3'd4, 32'd3, 32'd7, 5'd15, 32'd0); checkOutput(0);
    applyStimulus(3'd0, 32'd0, 32'd9, 5'd16, 32'd0); checkOutput(0);
    applyStimulus(3'd6, 32'hFFFFFFFD, 32'd7, 5'd17, 32'hFFFFFFFD); checkOutput(0);
    applyStimulus(3'd7, 32'd7, 32'd3, 5'd18, 32'd1); checkOutput(0);

    for (int i = 0; i < 8; i++) begin
      rop = op_list[$urandom_range(0, 6)];
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      applyStimulus(rop, ra, rb, 5'(i + 20), modelResult(rop, ra, rb));
      checkOutput(i % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
